// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the SRAM external-port arbiter.
// The lock feature (enabled with the SRAM_ARB_LOCK_EN macro) uses lock_state_t.
package sram_arb_pkg;

   localparam int ADDR_W           = 64;
   localparam int N_REQ_DEFAULT    = 4;
   localparam int DATA_W_DEFAULT   = 32;
   localparam int MAX_LOCK_DEFAULT = 16;
   localparam int REQ_IDX_W        = $clog2(N_REQ_DEFAULT);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational round-robin picker: the first valid requester found when
// scanning from rr_ptr+1 upward, wrapping modulo N_REQ, wins.
module sram_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan every position once, starting just past the previous winner
   always_comb begin
      logic [IDX_W-1:0] cand;
      cand   = '0;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (!any && valid[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
      if (any) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/sram_ext_port_arbiter.sv
// Round-robin arbiter sharing the external SRAM port among N_REQ requesters.
// One beat per cycle; read data returns to the issuer one cycle later.
// Optional grant locking is enabled by defining SRAM_ARB_LOCK_EN.
module sram_ext_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
`ifdef SRAM_ARB_LOCK_EN
   ,
   parameter int MAX_LOCK = MAX_LOCK_DEFAULT
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ-1:0]        req_wen,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_wdata,
`ifdef SRAM_ARB_LOCK_EN
   input  logic [N_REQ-1:0]        req_lock,
`endif
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic                    mem_wen,
   output logic                    mem_ren,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic [DATA_W-1:0]       mem_rdata
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] win_idx;
   logic [N_REQ-1:0] pick_valid;
   logic [N_REQ-1:0] grant;
   logic             accept;
   logic             win_wen;

   sram_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .valid  (pick_valid),
      .rr_ptr (rr_ptr),
      .onehot (grant),
      .idx    (win_idx),
      .any    (accept)
   );

   assign req_ready = grant;
   assign win_wen   = req_wen[win_idx];

`ifdef SRAM_ARB_LOCK_EN
   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   lock_state_t      lock_state, lock_state_nxt;
   logic [IDX_W-1:0] lock_owner, lock_owner_nxt;
   logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;

   // Lock state, owner and beat counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_state <= UNLOCKED;
         lock_owner <= '0;
         lock_cnt   <= '0;
      end else begin
         lock_state <= lock_state_nxt;
         lock_owner <= lock_owner_nxt;
         lock_cnt   <= lock_cnt_nxt;
      end
   end

   // While locked, only the owner may compete; an absent owner gets no grant
   always_comb begin
      pick_valid = req_valid;
      if (lock_state == LOCKED) begin
         pick_valid             = '0;
         pick_valid[lock_owner] = req_valid[lock_owner];
      end
   end

   // Enter on a locked beat; leave on unlock, owner gap or hitting MAX_LOCK
   always_comb begin
      lock_state_nxt = lock_state;
      lock_owner_nxt = lock_owner;
      lock_cnt_nxt   = lock_cnt;
      case (lock_state)
         UNLOCKED: begin
            if (accept && req_lock[win_idx] && (MAX_LOCK > 1)) begin
               lock_state_nxt = LOCKED;
               lock_owner_nxt = win_idx;
               lock_cnt_nxt   = CNT_W'(1);
            end
         end
         LOCKED: begin
            if (!req_valid[lock_owner]) begin
               lock_state_nxt = UNLOCKED;
               lock_cnt_nxt   = '0;
            end else if (!req_lock[lock_owner] ||
                         (lock_cnt >= CNT_W'(MAX_LOCK - 1))) begin
               lock_state_nxt = UNLOCKED;
               lock_cnt_nxt   = '0;
            end else begin
               lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end
         end
         default: begin
            lock_state_nxt = UNLOCKED;
            lock_cnt_nxt   = '0;
         end
      endcase
   end
`else
   assign pick_valid = req_valid;
`endif

   // Round-robin pointer and the one-cycle read response pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr    <= IDX_W'(N_REQ - 1);
         rsp_valid <= '0;
      end else begin
         if (accept) begin
            rr_ptr <= win_idx;
         end
         rsp_valid <= (accept && !win_wen) ? grant : '0;
      end
   end

   // Drive the memory port from the winner, or hold it quiet when idle
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wen   = 1'b0;
      mem_ren   = 1'b0;
      if (accept) begin
         mem_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
         mem_wdata = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
         mem_wen   = win_wen;
         mem_ren   = !win_wen;
      end
   end

   assign rsp_rdata = (|rsp_valid) ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_ext_port_arbiter.sv
// Randomised scoreboard bench for sram_ext_port_arbiter with an SRAM model.
module tb_sram_ext_port_arbiter;
   import sram_arb_pkg::*;

   localparam int N  = N_REQ_DEFAULT;
   localparam int DW = DATA_W_DEFAULT;
   localparam int ML = MAX_LOCK_DEFAULT;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      int            due;
   } rsp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      req_wen = '0;
   logic [N*64-1:0]   req_addr = '0;
   logic [N*DW-1:0]   req_wdata = '0;
   logic [N-1:0]      req_lock = '0;
   logic [N-1:0]      rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic [63:0]       mem_addr;
   logic              mem_wen;
   logic              mem_ren;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata = '0;

   logic [DW-1:0]     sram   [0:255];
   logic [DW-1:0]     shadow [0:255];
   logic [63:0]       beat_addr [N];
   logic [DW-1:0]     beat_data [N];

   rsp_t              exp_q[$];
   int                n_cmp = 0;
   int                n_err = 0;
   int                cyc = 0;
   int                ref_ptr = N - 1;
   bit                armed = 1'b0;
   bit                lk_on = 1'b0;
   int                lk_owner = 0;
   int                lk_cnt = 0;
   logic [REQ_IDX_W-1:0] last_win = '0;

   sram_ext_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
`ifdef SRAM_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_addr  (mem_addr),
      .mem_wen   (mem_wen),
      .mem_ren   (mem_ren),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous SRAM behind the external port: read data one cycle later
   always @(posedge clk) begin
      if (mem_wen) sram[mem_addr[9:2]] <= mem_wdata;
      if (mem_ren) mem_rdata <= sram[mem_addr[9:2]];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("[TB] FAIL %s cyc=%0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
      end
   endtask

   // Response side: pop the scoreboard whenever the DUT presents a response
   task automatic checkOutput();
      rsp_t e;
      logic [N-1:0] oh;
      if (!armed) return;
      if (rsp_valid != '0) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
         end else begin
            e  = exp_q.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            check("rsp_valid", 64'(rsp_valid), 64'(oh));
            check("rsp_timing", 64'(cyc), 64'(e.due));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
         end
      end else begin
         check("rsp_idle_data", 64'(rsp_rdata), 64'd0);
         if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e  = exp_q.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            check("rsp_missing", 64'(rsp_valid), 64'(oh));
         end
      end
   endtask

   // Reference model: grant rule, memory drive, shadow memory and lock rules
   task automatic modelStep();
      int           win;
      int           c;
      logic [N-1:0] exp_ready;
      logic [63:0]  a;
      logic [DW-1:0] d;
      rsp_t         e;
      win = -1;
      if (lk_on) begin
         if (req_valid[lk_owner]) win = lk_owner;
      end else begin
         for (int k = 1; k <= N; k++) begin
            c = (ref_ptr + k) % N;
            if (win < 0 && req_valid[c]) win = c;
         end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      if (armed) begin
         check("req_ready", 64'(req_ready), 64'(exp_ready));
         if (win >= 0) begin
            a = req_addr[win*64 +: 64];
            d = req_wdata[win*DW +: DW];
            check("mem_wen", 64'(mem_wen), 64'(req_wen[win]));
            check("mem_ren", 64'(mem_ren), 64'(!req_wen[win]));
            check("mem_addr", mem_addr, a);
            if (req_wen[win]) check("mem_wdata", 64'(mem_wdata), 64'(d));
         end else begin
            check("mem_idle", {mem_addr[61:0], mem_wen, mem_ren} | 64'(mem_wdata), 64'd0);
         end
      end
      if (win >= 0) begin
         a = req_addr[win*64 +: 64];
         last_win = REQ_IDX_W'(win);
         if (req_wen[win]) begin
            shadow[a[9:2]] = req_wdata[win*DW +: DW];
         end else if (!rst && armed) begin
            e.idx  = win;
            e.data = shadow[a[9:2]];
            e.due  = cyc + 1;
            exp_q.push_back(e);
         end
      end
      if (rst) begin
         ref_ptr = N - 1;
         lk_on   = 1'b0;
         lk_cnt  = 0;
         exp_q.delete();
         armed   = 1'b1;
      end else begin
         if (win >= 0) ref_ptr = win;
         if (!lk_on) begin
            if (win >= 0 && req_lock[win]) begin
               lk_on    = 1'b1;
               lk_owner = win;
               lk_cnt   = 1;
            end
         end else if (win < 0) begin
            lk_on = 1'b0;
         end else begin
            lk_cnt++;
            if (!req_lock[lk_owner] || lk_cnt >= ML) lk_on = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      checkOutput();
      modelStep();
      cyc++;
   end

   // Drive one cycle of requests; addresses and data come from beat_addr/beat_data
   task automatic applyStimulus(input logic r, input logic [N-1:0] v,
                                input logic [N-1:0] w, input logic [N-1:0] lk);
      rst       = r;
      req_valid = v;
      req_wen   = w;
      req_lock  = lk;
      for (int i = 0; i < N; i++) begin
         req_addr[i*64 +: 64]  = beat_addr[i];
         req_wdata[i*DW +: DW] = beat_data[i];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic randomBeats();
      for (int i = 0; i < N; i++) begin
         beat_addr[i] = {$urandom(), $urandom()} & ~64'h3;
         beat_data[i] = DW'($urandom());
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         sram[i]   = 32'hA500_0000 ^ (i * 32'h0101_0101);
         shadow[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
      end
      for (int i = 0; i < N; i++) begin
         beat_addr[i] = 64'h100 + 64'(i * 4);
         beat_data[i] = '0;
      end

      repeat (3) applyStimulus(1'b1, '0, '0, '0);

      $display("[TB] all four requesters reading");
      repeat (5) applyStimulus(1'b0, 4'b1111, 4'b0000, '0);

      $display("[TB] write then read of address 0x40");
      beat_addr[2] = 64'h40;
      beat_data[2] = 32'hDEAD_BEEF;
      beat_addr[0] = 64'h40;
      applyStimulus(1'b0, 4'b0100, 4'b0100, '0);
      applyStimulus(1'b0, 4'b0001, 4'b0000, '0);
      applyStimulus(1'b0, 4'b0000, 4'b0000, '0);

      $display("[TB] requester 3 back-to-back reads");
      for (int i = 0; i < 10; i++) begin
         beat_addr[3] = 64'(i * 8);
         applyStimulus(1'b0, 4'b1000, 4'b0000, '0);
      end

      $display("[TB] reset during an accepted read");
      beat_addr[1] = 64'h80;
      applyStimulus(1'b1, 4'b0010, 4'b0000, '0);
      applyStimulus(1'b0, 4'b1111, 4'b0000, '0);

      $display("[TB] idle cycles keep the pointer");
      repeat (5) applyStimulus(1'b0, 4'b0000, 4'b0000, '0);
      applyStimulus(1'b0, 4'b1111, 4'b0000, '0);
      applyStimulus(1'b0, 4'b0000, 4'b0000, '0);

`ifdef SRAM_ARB_LOCK_EN
      $display("[TB] requester 1 holds a lock while requester 0 waits");
      applyStimulus(1'b0, 4'b0001, 4'b0000, '0);
      for (int i = 0; i < 22; i++) begin
         beat_addr[1] = 64'(i * 4);
         applyStimulus(1'b0, 4'b0011, 4'b0000, 4'b0010);
      end
      applyStimulus(1'b0, 4'b0000, 4'b0000, '0);
`endif

      $display("[TB] randomised traffic");
      for (int i = 0; i < 400; i++) begin
         randomBeats();
         applyStimulus(1'b0, N'($urandom()), N'($urandom()),
`ifdef SRAM_ARB_LOCK_EN
                       N'($urandom()) & N'($urandom())
`else
                       '0
`endif
                       );
      end

      repeat (4) applyStimulus(1'b0, '0, '0, '0);
      check("pending_rsp", 64'(exp_q.size()), 64'd0);
      $display("[TB] last granted requester %0d", last_win);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
